// File: rtl/c64_kbd_pkg.sv
// Shared PS/2 constants, receiver states and matrix position type for the C64 keyboard front end.
package c64_kbd_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_BATERR = 8'hFC;
    localparam logic [7:0] PS2_PGUP   = 8'h7D;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [2:0] line;
        logic [2:0] col;
    } matrix_pos_t;

    function automatic matrix_pos_t mk_pos(input logic [2:0] line, input logic [2:0] col);
        matrix_pos_t p;
        p.hit  = 1'b1;
        p.line = line;
        p.col  = col;
        return p;
    endfunction

    // Keyboard housekeeping replies, never key codes when no prefix is pending.
    function automatic logic is_status(input logic [7:0] code);
        return (code == PS2_BAT) || (code == PS2_ACK) ||
               (code == PS2_ECHO) || (code == PS2_BATERR);
    endfunction

endpackage

// File: rtl/ps2_c64_keymap.sv
// Combinational translation of PS/2 set-2 codes ({ext, code}) to C64 matrix positions.
module ps2_c64_keymap
    import c64_kbd_pkg::*;
(
    input  logic        ext,
    input  logic [7:0]  code,
    output matrix_pos_t pos
);

    always_comb begin
        pos = '0;
        case ({ext, code})
            9'h066: pos = mk_pos(3'd0, 3'd0);  // Backspace -> DEL
            9'h05A: pos = mk_pos(3'd0, 3'd1);
            9'h174: pos = mk_pos(3'd0, 3'd2);
            9'h083: pos = mk_pos(3'd0, 3'd3);
            9'h005: pos = mk_pos(3'd0, 3'd4);
            9'h004: pos = mk_pos(3'd0, 3'd5);
            9'h003: pos = mk_pos(3'd0, 3'd6);
            9'h172: pos = mk_pos(3'd0, 3'd7);
            9'h026: pos = mk_pos(3'd1, 3'd0);
            9'h01D: pos = mk_pos(3'd1, 3'd1);
            9'h01C: pos = mk_pos(3'd1, 3'd2);
            9'h025: pos = mk_pos(3'd1, 3'd3);
            9'h01A: pos = mk_pos(3'd1, 3'd4);
            9'h01B: pos = mk_pos(3'd1, 3'd5);
            9'h024: pos = mk_pos(3'd1, 3'd6);
            9'h012: pos = mk_pos(3'd1, 3'd7);
            9'h02E: pos = mk_pos(3'd2, 3'd0);
            9'h02D: pos = mk_pos(3'd2, 3'd1);
            9'h023: pos = mk_pos(3'd2, 3'd2);
            9'h036: pos = mk_pos(3'd2, 3'd3);
            9'h021: pos = mk_pos(3'd2, 3'd4);
            9'h02B: pos = mk_pos(3'd2, 3'd5);
            9'h02C: pos = mk_pos(3'd2, 3'd6);
            9'h022: pos = mk_pos(3'd2, 3'd7);
            9'h03D: pos = mk_pos(3'd3, 3'd0);
            9'h035: pos = mk_pos(3'd3, 3'd1);
            9'h034: pos = mk_pos(3'd3, 3'd2);
            9'h03E: pos = mk_pos(3'd3, 3'd3);
            9'h032: pos = mk_pos(3'd3, 3'd4);
            9'h033: pos = mk_pos(3'd3, 3'd5);
            9'h03C: pos = mk_pos(3'd3, 3'd6);
            9'h02A: pos = mk_pos(3'd3, 3'd7);
            9'h046: pos = mk_pos(3'd4, 3'd0);
            9'h043: pos = mk_pos(3'd4, 3'd1);
            9'h03B: pos = mk_pos(3'd4, 3'd2);
            9'h045: pos = mk_pos(3'd4, 3'd3);
            9'h03A: pos = mk_pos(3'd4, 3'd4);
            9'h042: pos = mk_pos(3'd4, 3'd5);
            9'h044: pos = mk_pos(3'd4, 3'd6);
            9'h031: pos = mk_pos(3'd4, 3'd7);
            9'h04E: pos = mk_pos(3'd5, 3'd3);
            9'h04D: pos = mk_pos(3'd5, 3'd1);
            9'h04B: pos = mk_pos(3'd5, 3'd2);
            9'h049: pos = mk_pos(3'd5, 3'd4);
            9'h04C: pos = mk_pos(3'd5, 3'd5);
            9'h054: pos = mk_pos(3'd5, 3'd6);
            9'h041: pos = mk_pos(3'd5, 3'd7);
            9'h05B: pos = mk_pos(3'd6, 3'd1);
            9'h052: pos = mk_pos(3'd6, 3'd2);
            9'h16C: pos = mk_pos(3'd6, 3'd3);
            9'h059: pos = mk_pos(3'd6, 3'd4);
            9'h055: pos = mk_pos(3'd6, 3'd5);
            9'h04A: pos = mk_pos(3'd6, 3'd7);
            9'h016: pos = mk_pos(3'd7, 3'd0);
            9'h00E: pos = mk_pos(3'd7, 3'd1);
            9'h014: pos = mk_pos(3'd7, 3'd2);
            9'h114: pos = mk_pos(3'd7, 3'd2);
            9'h01E: pos = mk_pos(3'd7, 3'd3);
            9'h029: pos = mk_pos(3'd7, 3'd4);
            9'h11F: pos = mk_pos(3'd7, 3'd5);
            9'h015: pos = mk_pos(3'd7, 3'd6);
            9'h076: pos = mk_pos(3'd7, 3'd7);  // Esc -> RUN/STOP
            default: pos = '0;
        endcase
    end

endmodule

// File: rtl/ps2_c64_keyboard.sv
// PS/2 receiver and decoder maintaining a C64 8x8 key matrix scanned by CIA1.
// Optional mid-frame watchdog enabled by defining PS2_WATCHDOG_EN.
module ps2_c64_keyboard
    import c64_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic       dot_clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] keyboard_ROW,
    output logic [7:0] keyboard_COL,
    output logic       restore,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN);

    if (FILTER_LEN < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("ps2_c64_keyboard: FILTER_LEN and TIMEOUT_CYCLES must be at least 2");
    end

    logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic            filt_q, filt_d, filt_dly_q;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            fall;

    rx_state_e       state_q, state_d;
    logic [2:0]      bcnt_q, bcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [7:0]      byte_q, byte_d;
    logic            vld_q, vld_d;
    logic            ferr_q, ferr_d;

    logic            ext_q, ext_d, rel_q, rel_d;
    logic [7:0][7:0] mtx_q, mtx_d;
    logic            rest_q, rest_d;
    logic [7:0]      col_q, col_d;
    matrix_pos_t     pos;

`ifdef PS2_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    ps2_c64_keymap u_keymap (
        .ext  (ext_q),
        .code (byte_q),
        .pos  (pos)
    );

    assign fall = filt_dly_q & ~filt_q;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        byte_d  = byte_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d = RX_DATA;
                        bcnt_d  = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (dat_s2_q && ((^shift_q) ^ par_q)) begin
                        vld_d  = 1'b1;
                        byte_d = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
`ifdef PS2_WATCHDOG_EN
        wd_d = '0;
        if (state_q != RX_IDLE && !fall) begin
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = RX_IDLE;
                ferr_d  = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
`endif
    end

    // Prefix bytes only arm flags; every other byte consumes and clears them.
    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        mtx_d  = mtx_q;
        rest_d = rest_q;
        if (vld_q) begin
            if (byte_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_REL) begin
                rel_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                rel_d = 1'b0;
                if (ext_q || rel_q || !is_status(byte_q)) begin
                    if (ext_q && byte_q == PS2_PGUP) begin
                        rest_d = ~rel_q;
                    end else if (pos.hit) begin
                        mtx_d[pos.line][pos.col] = ~rel_q;
                    end
                end
            end
        end
        if (ferr_q) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end
    end

    always_comb begin
        col_d = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            if (!keyboard_ROW[r]) col_d = col_d & ~mtx_q[r];
        end
    end

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
            fcnt_q     <= '0;
            state_q    <= RX_IDLE;
            bcnt_q     <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            byte_q     <= '0;
            vld_q      <= 1'b0;
            ferr_q     <= 1'b0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            mtx_q      <= '0;
            rest_q     <= 1'b0;
            col_q      <= 8'hFF;
`ifdef PS2_WATCHDOG_EN
            wd_q       <= '0;
`endif
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            byte_q     <= byte_d;
            vld_q      <= vld_d;
            ferr_q     <= ferr_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            mtx_q      <= mtx_d;
            rest_q     <= rest_d;
            col_q      <= col_d;
`ifdef PS2_WATCHDOG_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign keyboard_COL = col_q;
    assign restore      = rest_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_ps2_c64_keyboard.sv
// Directed bench: table of PS/2 frames with expected matrix sense output, plus reset/latency sequences.
module tb_ps2_c64_keyboard;

    localparam int TIMEOUT_CYCLES = 16384;

    logic       dot_clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keyboard_ROW = 8'hFF;
    logic [7:0] keyboard_COL;
    logic       restore;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;

    ps2_c64_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .dot_clk      (dot_clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keyboard_ROW (keyboard_ROW),
        .keyboard_COL (keyboard_COL),
        .restore      (restore),
        .frame_err    (frame_err)
    );

    always #5 dot_clk = ~dot_clk;

    always @(posedge dot_clk) if (frame_err) err_cnt <= err_cnt + 1;

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic [7:0] row;
        logic [7:0] col;
        int         errs;
        logic       rest;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (10) @(posedge dot_clk);
        ps2_clk = 1'b0;
        repeat (20) @(posedge dot_clk);
        ps2_clk = 1'b1;
        repeat (20) @(posedge dot_clk);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad);
        logic p;
        p = (~^code) ^ bad;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(p);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (30) @(posedge dot_clk);
    endtask

    task automatic do_reset();
        @(negedge dot_clk);
        reset = 1'b1;
        repeat (3) @(posedge dot_clk);
        @(negedge dot_clk);
        reset = 1'b0;
    endtask

    initial begin
        int e0;
        vecs[0]  = '{8'h1C, 1'b0, 8'hFD, 8'hFB, 0, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 8'hFD, 8'hFB, 0, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 8'hFD, 8'hFF, 0, 1'b0};
        vecs[3]  = '{8'h29, 1'b1, 8'h7F, 8'hFF, 1, 1'b0};
        vecs[4]  = '{8'h29, 1'b0, 8'h7F, 8'hEF, 0, 1'b0};
        vecs[5]  = '{8'hF0, 1'b0, 8'h7F, 8'hEF, 0, 1'b0};
        vecs[6]  = '{8'h29, 1'b0, 8'h7F, 8'hFF, 0, 1'b0};
        vecs[7]  = '{8'hE0, 1'b0, 8'hFF, 8'hFF, 0, 1'b0};
        vecs[8]  = '{8'h7D, 1'b0, 8'hFD, 8'hFF, 0, 1'b1};
        vecs[9]  = '{8'hE0, 1'b0, 8'hFF, 8'hFF, 0, 1'b1};
        vecs[10] = '{8'hF0, 1'b0, 8'hFF, 8'hFF, 0, 1'b1};
        vecs[11] = '{8'h7D, 1'b0, 8'hFF, 8'hFF, 0, 1'b0};
        vecs[12] = '{8'h1C, 1'b0, 8'hFD, 8'hFB, 0, 1'b0};
        vecs[13] = '{8'h5A, 1'b0, 8'hFC, 8'hF9, 0, 1'b0};
        vecs[14] = '{8'hAA, 1'b0, 8'hFE, 8'hFD, 0, 1'b0};
        vecs[15] = '{8'h12, 1'b0, 8'hFD, 8'h7B, 0, 1'b0};
        vecs[16] = '{8'hE0, 1'b0, 8'hFE, 8'hFD, 0, 1'b0};
        vecs[17] = '{8'h74, 1'b0, 8'hFE, 8'hF9, 0, 1'b0};
        vecs[18] = '{8'hE0, 1'b0, 8'hFF, 8'hFF, 0, 1'b0};
        vecs[19] = '{8'h55, 1'b1, 8'hFF, 8'hFF, 1, 1'b0};
        vecs[20] = '{8'h7D, 1'b0, 8'hFF, 8'hFF, 0, 1'b0};

        repeat (4) @(posedge dot_clk);
        @(negedge dot_clk);
        reset = 1'b0;
        @(negedge dot_clk);
        check("reset_col", keyboard_COL, 8'hFF);
        check("reset_restore", {7'd0, restore}, 8'h00);
        check("reset_frame_err", {7'd0, frame_err}, 8'h00);

        for (int i = 0; i < 21; i++) begin
            keyboard_ROW = vecs[i].row;
            e0 = err_cnt;
            send_frame(vecs[i].code, vecs[i].bad_par);
            @(negedge dot_clk);
            check($sformatf("vec%0d_col", i), keyboard_COL, vecs[i].col);
            check($sformatf("vec%0d_restore", i), {7'd0, restore}, {7'd0, vecs[i].rest});
            check($sformatf("vec%0d_err_cycles", i), 8'(err_cnt - e0), 8'(vecs[i].errs));
        end

        // Row change is registered: old value until the next edge, new value right after.
        keyboard_ROW = 8'hFD;
        repeat (3) @(negedge dot_clk);
        check("row_lat_before", keyboard_COL, 8'h7B);
        keyboard_ROW = 8'hFF;
        #1;
        check("row_lat_hold", keyboard_COL, 8'h7B);
        @(negedge dot_clk);
        check("row_lat_after", keyboard_COL, 8'hFF);

        // Hold RESTORE, then reset clears it and the whole matrix.
        send_frame(8'hE0, 1'b0);
        send_frame(8'h7D, 1'b0);
        @(negedge dot_clk);
        check("restore_held", {7'd0, restore}, 8'h01);
        keyboard_ROW = 8'h00;
        do_reset();
        @(negedge dot_clk);
        @(negedge dot_clk);
        check("post_reset_col", keyboard_COL, 8'hFF);
        check("post_reset_restore", {7'd0, restore}, 8'h00);

        // Partial frame interrupted by reset must be discarded.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        do_reset();
        keyboard_ROW = 8'hFD;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0);
        @(negedge dot_clk);
        check("midframe_reset_col", keyboard_COL, 8'hFB);
        check("midframe_reset_err", 8'(err_cnt - e0), 8'd0);

`ifdef PS2_WATCHDOG_EN
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        repeat (TIMEOUT_CYCLES + 200) @(posedge dot_clk);
        @(negedge dot_clk);
        check("watchdog_err", 8'(err_cnt - e0), 8'd1);
        keyboard_ROW = 8'hFE;
        e0 = err_cnt;
        send_frame(8'h5A, 1'b0);
        @(negedge dot_clk);
        check("watchdog_recover_col", keyboard_COL, 8'hFD);
        check("watchdog_recover_err", 8'(err_cnt - e0), 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
